// File: rtl/mult_sched.sv
// Job scheduler: streams operand pairs 0..DEPTH-1 into a multiplier, waits, then collects DEPTH readback beats.
// Optional build macro MULT_SCHED_CHECK_EN adds a k*k readback data check that raises err on mismatch.
module mult_sched #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             EN_mult,
    input  logic             RDY_mult,
    output logic [15:0]      mult_input0,
    output logic [15:0]      mult_input1,
    output logic             EN_blockRead,
    input  logic             VALID_memVal,
    input  logic [WIDTH-1:0] memVal_data,
    output logic [6:0]       rd_count,
    output logic [2:0]       dbg_state
);

    localparam int IW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    // Handshake: a write beat transfers on a clock where EN_mult && RDY_mult are
    // both high; a readback beat transfers on any READ clock with VALID_memVal high.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        GAP  = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WW-1:0]   wd_cnt;
    logic            gap_cnt;
    logic            mismatch;

`ifdef MULT_SCHED_CHECK_EN
    logic [WIDTH-1:0] exp_sq;
    assign exp_sq   = WIDTH'(rd_count) * WIDTH'(rd_count);
    assign mismatch = (memVal_data != exp_sq);
`else
    logic unused_data;
    assign unused_data = ^memVal_data;
    assign mismatch    = 1'b0;
`endif

    assign mult_input0 = {{(16 - IW){1'b0}}, idx};
    assign mult_input1 = {{(16 - IW){1'b0}}, idx};
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            EN_mult      <= 1'b0;
            EN_blockRead <= 1'b0;
            idx          <= '0;
            rd_count     <= '0;
            wd_cnt       <= '0;
            gap_cnt      <= 1'b0;
        end else begin
            done         <= 1'b0;
            EN_blockRead <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                busy    <= 1'b0;
                EN_mult <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= MULT;
                            busy     <= 1'b1;
                            EN_mult  <= 1'b1;
                            err      <= 1'b0;
                            idx      <= '0;
                            rd_count <= '0;
                            wd_cnt   <= '0;
                            gap_cnt  <= 1'b0;
                        end
                    end
                    MULT: begin
                        if (RDY_mult) begin
                            // idx parks on the last beat rather than wrapping
                            if (idx == IW'(DEPTH - 1)) begin
                                state   <= GAP;
                                EN_mult <= 1'b0;
                                gap_cnt <= 1'b0;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt) begin
                            state        <= READ;
                            EN_blockRead <= 1'b1;
                            wd_cnt       <= '0;
                        end else begin
                            gap_cnt <= 1'b1;
                        end
                    end
                    READ: begin
                        if (VALID_memVal) begin
                            wd_cnt   <= '0;
                            rd_count <= rd_count + 7'd1;
                            if (mismatch) err <= 1'b1;
                            if (rd_count == 7'(DEPTH - 1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + WW'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        EN_mult <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
